quad_decoder_mc: RTL

Parametrised multi-channel quadrature encoder decoder that succeeds the single-channel `encoder4sig`. Each channel takes raw {Index, A, B} encoder lines and produces:
- a wrapping signed angular position,
- a step period measured against the shared free-running `ctime` timestamp,
- direction, a step strobe, and a sticky illegal-transition flag.

It sits between the encoder input pins and the motor-control/telemetry logic. Over `encoder4sig`, it adds per-channel input synchronisation, glitch filtering, index-pulse zeroing, stall-aware period growth and error detection.

---
 rtl/quad_decoder_mc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder_mc.sv
// rtl/quad_decoder_mc.sv - multi-channel quadrature encoder decoder
//
// Purpose: decodes CHANNELS independent {Index, A, B} encoder inputs into a
// wrapping signed position, a same-direction step period measured on the
// shared ctime timestamp, direction, a one-cycle step strobe and a sticky
// illegal-transition flag.
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_enc      channel c = i_enc[3c+2:3c] = {Index, A, B}, asynchronous
//   i_ctime    free-running timestamp, +1 per clock
//   i_err_clr  per-channel level clear of o_err
//   o_angpos   channel c at [POS_W*c +: POS_W], two's complement, wrapping
//   o_period   channel c at [PER_W*c +: PER_W], ticks between steps, saturating
//   o_dir      1 = last valid step was clockwise
//   o_step     one-cycle pulse per valid step
//   o_err      sticky illegal-transition flag
module quad_decoder_mc #(
  parameter int CHANNELS  = 4,
  parameter int POS_W     = 32,
  parameter int TIME_W    = 51,
  parameter int PER_W     = 32,
  parameter int FILT      = 2,
  parameter int INDEX_CLR = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [3*CHANNELS-1:0]       i_enc,
  input  logic [TIME_W-1:0]           i_ctime,
  input  logic [CHANNELS-1:0]         i_err_clr,
  output logic [POS_W*CHANNELS-1:0]   o_angpos,
  output logic [PER_W*CHANNELS-1:0]   o_period,
  output logic [CHANNELS-1:0]         o_dir,
  output logic [CHANNELS-1:0]         o_step,
  output logic [CHANNELS-1:0]         o_err
);

  localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

  // Arming window: three cycles after reset in which the filters load the
  // synchronised inputs directly so a non-00 rest position is not counted.
  logic [1:0] r_arm;
  logic       w_armed;

  assign w_armed = (r_arm == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arm <= 2'd0;
    end else if (!w_armed) begin
      r_arm <= r_arm + 2'd1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [2:0]        r_s1;
    logic [2:0]        r_s2;
    logic [2:0]        r_filt;
    logic [2:0]        r_prev;
    logic [CNT_W-1:0]  r_cnt [3];
    logic [POS_W-1:0]  r_pos;
    logic [PER_W-1:0]  r_per;
    logic              r_dir;
    logic              r_step;
    logic              r_err;
    logic              r_first;
    logic [TIME_W-1:0] r_last_ts;

    logic [TIME_W-1:0] w_elapsed;
    logic [PER_W-1:0]  w_el_sat;
    logic [1:0]        w_prev_q;
    logic [1:0]        w_cur_q;
    logic [1:0]        w_delta;
    logic              w_cw;
    logic              w_ccw;
    logic              w_illegal;
    logic              w_idx_rise;
    logic              w_valid;

    // Synchroniser, per-bit glitch filter and previous-state register.
    // Bit order within a channel: [2] = Index, [1] = A, [0] = B.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_s1   <= 3'b000;
        r_s2   <= 3'b000;
        r_filt <= 3'b000;
        r_prev <= 3'b000;
        for (int b = 0; b < 3; b++) r_cnt[b] <= '0;
      end else begin
        r_s1 <= i_enc[3*c +: 3];
        r_s2 <= r_s1;
        if (!w_armed) begin
          // prev follows s2 too, so the first armed cycle sees no change
          r_filt <= r_s2;
          r_prev <= r_s2;
          for (int b = 0; b < 3; b++) r_cnt[b] <= '0;
        end else begin
          r_prev <= r_filt;
          for (int b = 0; b < 3; b++) begin
            if (r_s2[b] == r_filt[b]) begin
              r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_LAST) begin
              r_filt[b] <= r_s2[b];
              r_cnt[b]  <= '0;
            end else begin
              r_cnt[b] <= r_cnt[b] + CNT_W'(1);
            end
          end
        end
      end
    end

    // Map AB onto a 2-bit quadrant counting clockwise (00,10,11,01 -> 0..3);
    // the modulo-4 difference then classifies the transition directly.
    assign w_prev_q   = {r_prev[0], r_prev[1] ^ r_prev[0]};
    assign w_cur_q    = {r_filt[0], r_filt[1] ^ r_filt[0]};
    assign w_delta    = w_cur_q - w_prev_q;
    assign w_cw       = w_armed && (w_delta == 2'd1);
    assign w_ccw      = w_armed && (w_delta == 2'd3);
    assign w_illegal  = w_armed && (w_delta == 2'd2);
    assign w_valid    = w_cw || w_ccw;
    assign w_idx_rise = (INDEX_CLR != 0) && w_armed && r_filt[2] && !r_prev[2];

    assign w_elapsed  = i_ctime - r_last_ts;

    if (PER_W >= TIME_W) begin : g_nosat
      assign w_el_sat = PER_W'(w_elapsed);
    end else begin : g_sat
      assign w_el_sat = (|w_elapsed[TIME_W-1:PER_W]) ? '1 : w_elapsed[PER_W-1:0];
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_pos     <= '0;
        r_per     <= '1;
        r_dir     <= 1'b0;
        r_step    <= 1'b0;
        r_err     <= 1'b0;
        r_first   <= 1'b1;
        r_last_ts <= '0;
      end else begin
        r_step <= w_valid;

        if (w_idx_rise) begin
          r_pos <= '0;
        end else if (w_cw) begin
          r_pos <= r_pos + POS_W'(1);
        end else if (w_ccw) begin
          r_pos <= r_pos - POS_W'(1);
        end

        if (w_valid) begin
          r_dir     <= w_cw;
          r_last_ts <= i_ctime;
          r_first   <= 1'b0;
          // A reversal or the first step has no meaningful previous interval
          if (r_first || (w_cw != r_dir)) begin
            r_per <= '1;
          end else begin
            r_per <= w_el_sat;
          end
        end else if (w_armed && !w_illegal && (w_el_sat > r_per)) begin
          // Stall growth: report at least the time since the last step
          r_per <= w_el_sat;
        end

        if (w_illegal) begin
          r_err <= 1'b1;
        end else if (i_err_clr[c]) begin
          r_err <= 1'b0;
        end
      end
    end

    assign o_angpos[POS_W*c +: POS_W] = r_pos;
    assign o_period[PER_W*c +: PER_W] = r_per;
    assign o_dir[c]                   = r_dir;
    assign o_step[c]                  = r_step;
    assign o_err[c]                   = r_err;
  end

endmodule
